sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
- Upstream neighbour of the 64-round compression datapath. It expands one 512-bit message block into the 64-word schedule W0..W63.
- It presents W_t (and optionally K_t) combinationally for the current round.
- It advances one word per `advance` pulse, in lock-step with the compression core's `next` strobe.
- Storage is a 16-word sliding window. Only one new word is computed per cycle, so no 64-word RAM is needed.

Parameters:
- ROUNDS, 64, number of schedule words produced per block. Fixed for SHA-256; exposed only for bench shortening.
- WIN, 16, sliding-window depth in 32-bit words.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- load  in  1  one-cycle pulse; capture block_in and start a new schedule.
- block_in  in  512  message block; M0 = block_in[511:480], M15 = block_in[31:0].
- advance  in  1  consume the current W_t and move to round t+1.
- w_out  out  32  W_t for the current round (window slot 0).
- k_out  out  32  K_t round constant (see Optional Feature).
- round  out  6  current round index t.
- valid  out  1  w_out/round hold a live word.
- last  out  1  valid and round == ROUNDS-1.
- sched_done  out  1  one-cycle pulse after W63 has been consumed.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on Reset. All state updates only on the rising edge of clk.
- Reset values (Reset==0 at an edge): window all 0, round=0, valid=0, sched_done=0. Therefore w_out=0, last=0, and k_out=K0 or 0.
- States: IDLE (valid=0), RUN (valid=1), DONE (sched_done=1 for one cycle, then IDLE).
- load, any state: next cycle window[i] = M_i, round=0, valid=1, enter RUN. W0 is visible the cycle after load (latency 1).
- advance in RUN:
  - window[i] <= window[i+1] for i=0..14.
  - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0], mod 2^32.
  - round <= round+1.
  - Net effect: W_{t+16} enters while W_t leaves.
- s0(x) = ROTR7 ^ ROTR18 ^ SHR3. s1(x) = ROTR17 ^ ROTR19 ^ SHR10. All adds are 32-bit wrap, carries discarded.
- advance while last=1: valid<=0, round<=0, enter DONE. sched_done=1 next cycle only.
- advance in IDLE or DONE: ignored, with no state change.
- load and advance in the same cycle: load wins and advance is dropped.
- load during RUN (mid-block): abort the current schedule and restart at round 0 with the new block. No sched_done for the aborted block.
- Reset mid-RUN: returns to IDLE with reset values. There is no partial completion.
- Words computed beyond W63 (window refill during rounds 48..63) are computed but never exposed.
- Outputs w_out, round, valid, last are registered-state driven, with no combinational path from advance.

Optional Feature:
- Macro SHA256_KROM_EN.
- Defined: a 64x32 constant ROM indexed by round drives k_out = K_round whenever valid; when valid=0, k_out = K0.
- Undefined: k_out is tied to 0, and the compression core sources K externally.

Decomposition:
- sha256_pkg holds:
  - typedef word_t (logic [31:0])
  - localparam ROUNDS=64, WIN=16
  - the K[0:63] constant array (used only under SHA256_KROM_EN)
  - state enum {IDLE, RUN, DONE}
- One sub-module: sha256_small_sigma. It is purely combinational: inputs x, outputs s0 and s1. The core instantiates it once for the single window update.

Test Plan:
- "abc" padded block (block_in = 0x61626380, 13x0x00000000, 0x00000000, 0x00000018), load, then 64 advances:
  - W0 = 0x61626380
  - W1..W14 = 0
  - W15 = 0x00000018
  - W16 = 0x61626380
  - W17 = 0x000F0000
  - last high at round 63
  - sched_done pulses exactly once
- SHA256_KROM_EN defined, "abc" block: k_out = 0x428A2F98 at round 0, 0x71374491 at round 1, 0xC67178F2 at round 63.
- load and advance in the same cycle while in RUN at round 20 -> round=0, w_out=new M0, no sched_done.
- Reset=0 held one edge at round 30 -> valid=0, round=0, w_out=0. 10 subsequent advances keep round=0 and valid=0.
- Random blocks (1000), full 64 advances with idle gaps between them -> every W_t matches the reference model; valid never drops before last.
- advance held high continuously after load -> exactly 64 valid words, then IDLE; extra advances are ignored.

Source files
------------

// File: rtl/sha256_msg_schedule_pkg.sv
// sha256_pkg: shared types, sizes and round constants for the SHA-256 message schedule.
package sha256_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ROUNDS = 64;
  localparam int WIN = 16;
  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
endpackage

// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: block load / round advance handshake and schedule word outputs.
interface sha256_msg_schedule_if;
  import sha256_pkg::*;
  logic load;
  logic advance;
  logic [511:0] block_in;
  word_t w_out;
  word_t k_out;
  logic [5:0] round;
  logic valid;
  logic last;
  logic sched_done;
  modport master(output load, advance, block_in, input w_out, k_out, round, valid, last, sched_done);
  modport slave(input load, advance, block_in, output w_out, k_out, round, valid, last, sched_done);
endinterface

// File: rtl/sha256_msg_schedule_sigma.sv
// sha256_small_sigma: combinational SHA-256 small sigma functions, s0 of x0 and s1 of x1.
module sha256_small_sigma
  import sha256_pkg::*;
(
  input  word_t x0,
  input  word_t x1,
  output word_t s0,
  output word_t s1
);
  assign s0 = {x0[6:0], x0[31:7]} ^ {x0[17:0], x0[31:18]} ^ (x0 >> 3);
  assign s1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ (x1 >> 10);
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: 16-word sliding-window expansion of one block into W0..W63; SHA256_KROM_EN adds the K_t ROM.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = sha256_pkg::ROUNDS,
  parameter int WIN = sha256_pkg::WIN
) (
  input logic clk,
  input logic Reset,
  sha256_msg_schedule_if.slave bus
);
  state_t state_q, state_d;
  logic [5:0] round_q, round_d;
  word_t win_q [WIN];
  word_t win_d [WIN];
  word_t s0, s1;
  logic valid, last;
  assign valid = state_q == RUN;
  assign last = valid && round_q == 6'(ROUNDS - 1);
  sha256_small_sigma u_sigma (.x0(win_q[1]), .x1(win_q[WIN-2]), .s0(s0), .s1(s1));
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    win_d = win_q;
    if (bus.load) begin
      for (int i = 0; i < WIN; i++) win_d[i] = bus.block_in[32*(WIN-i)-1 -: 32];
      round_d = '0;
      state_d = RUN;
    end else if (valid && bus.advance) begin
      for (int i = 0; i < WIN - 1; i++) win_d[i] = win_q[i+1];
      win_d[WIN-1] = s1 + win_q[WIN-7] + s0 + win_q[0];
      round_d = last ? '0 : round_q + 6'd1;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      round_q <= '0;
      win_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      win_q <= win_d;
    end
  end
  assign bus.w_out = win_q[0];
  assign bus.round = round_q;
  assign bus.valid = valid;
  assign bus.last = last;
  assign bus.sched_done = state_q == DONE;
`ifdef SHA256_KROM_EN
  assign bus.k_out = valid ? K[round_q] : K[0];
`else
  assign bus.k_out = '0;
`endif
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: randomized self-checking bench against a direct W_t recurrence model.
module tb_sha256_msg_schedule;
  logic clk = 0;
  logic rst_n = 0;
  int errors = 0;
  int checks = 0;
  logic [31:0] w_ref [64];
  logic [511:0] abc_blk;
  sha256_msg_schedule_if bus ();
  sha256_msg_schedule dut (.clk(clk), .Reset(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_ref(input logic [511:0] b);
    for (int t = 0; t < 16; t++) w_ref[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w_ref[t] = (rotr(w_ref[t-2], 17) ^ rotr(w_ref[t-2], 19) ^ (w_ref[t-2] >> 10)) + w_ref[t-7]
               + (rotr(w_ref[t-15], 7) ^ rotr(w_ref[t-15], 18) ^ (w_ref[t-15] >> 3)) + w_ref[t-16];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic load_block(input logic [511:0] b);
    build_ref(b);
    bus.block_in = b;
    bus.load = 1;
    tick();
    bus.load = 0;
  endtask

  task automatic play_block(input logic [511:0] b, input string tag);
    int dones = 0;
    load_block(b);
    for (int t = 0; t < 64; t++) begin
      checks++;
      if ({bus.valid, bus.last, bus.round, bus.w_out} !== {1'b1, t == 63, 6'(t), w_ref[t]}) begin
        errors++;
        $display("FAIL %s t=%0d: got valid=%b last=%b round=%0d w=%h, want valid=1 last=%b round=%0d w=%h",
                 tag, t, bus.valid, bus.last, bus.round, bus.w_out, t == 63, t, w_ref[t]);
      end
      if (bus.sched_done) dones++;
      bus.advance = 1;
      tick();
      bus.advance = 0;
    end
    if (bus.sched_done) dones++;
    checks++;
    if (bus.valid !== 1'b0 || bus.sched_done !== 1'b1) begin
      errors++;
      $display("FAIL %s end: got valid=%b done=%b, want valid=0 done=1", tag, bus.valid, bus.sched_done);
    end
    tick();
    if (bus.sched_done) dones++;
    checks++;
    if (dones != 1 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d valid=%b, want 1 valid=0", tag, dones, bus.valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    checks++;
    if ({bus.valid, bus.last, bus.sched_done, bus.round, bus.w_out} !== {3'b000, 6'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b l=%b d=%b r=%0d w=%h, want all 0",
               bus.valid, bus.last, bus.sched_done, bus.round, bus.w_out);
    end
    checks++;
`ifdef SHA256_KROM_EN
    if (bus.k_out !== 32'h428a2f98) begin
`else
    if (bus.k_out !== 32'h0) begin
`endif
      errors++;
      $display("FAIL reset_k: got %h", bus.k_out);
    end
  endtask

  task automatic test_abc;
    logic [31:0] exp_w;
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    load_block(abc_blk);
    for (int t = 0; t < 18; t++) begin
      exp_w = t == 0 ? 32'h61626380 : t == 15 ? 32'h18 : t == 16 ? 32'h61626380 : t == 17 ? 32'h000f0000 : 32'h0;
      checks++;
      if (bus.w_out !== exp_w) begin
        errors++;
        $display("FAIL abc_w%0d: got %h, want %h", t, bus.w_out, exp_w);
      end
`ifdef SHA256_KROM_EN
      if (t < 2) begin
        checks++;
        if (bus.k_out !== (t == 0 ? 32'h428a2f98 : 32'h71374491)) begin
          errors++;
          $display("FAIL abc_k%0d: got %h", t, bus.k_out);
        end
      end
`endif
      bus.advance = 1;
      tick();
      bus.advance = 0;
    end
    for (int t = 18; t < 63; t++) begin
      bus.advance = 1;
      tick();
      bus.advance = 0;
    end
    checks++;
    if (bus.last !== 1'b1 || bus.round !== 6'd63) begin
      errors++;
      $display("FAIL abc_last: got last=%b round=%0d, want last=1 round=63", bus.last, bus.round);
    end
`ifdef SHA256_KROM_EN
    checks++;
    if (bus.k_out !== 32'hc67178f2) begin
      errors++;
      $display("FAIL abc_k63: got %h, want c67178f2", bus.k_out);
    end
`endif
    play_block(abc_blk, "abc_full");
  endtask

  task automatic test_load_collision;
    logic [511:0] a, b;
    int dones = 0;
    a = rand_block();
    b = rand_block();
    load_block(a);
    for (int t = 0; t < 20; t++) begin
      bus.advance = 1;
      tick();
    end
    build_ref(b);
    bus.block_in = b;
    bus.load = 1;
    tick();
    bus.load = 0;
    checks++;
    if ({bus.valid, bus.round, bus.sched_done, bus.w_out} !== {1'b1, 6'd0, 1'b0, b[511:480]}) begin
      errors++;
      $display("FAIL collision: got v=%b r=%0d d=%b w=%h, want v=1 r=0 d=0 w=%h",
               bus.valid, bus.round, bus.sched_done, bus.w_out, b[511:480]);
    end
    for (int t = 0; t < 70; t++) begin
      tick();
      if (bus.sched_done) dones++;
    end
    bus.advance = 0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL collision_done: got %0d pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_mid;
    load_block(rand_block());
    for (int t = 0; t < 30; t++) begin
      bus.advance = 1;
      tick();
      bus.advance = 0;
    end
    checks++;
    if (bus.round !== 6'd30 || bus.w_out !== w_ref[30]) begin
      errors++;
      $display("FAIL pre_reset: got r=%0d w=%h, want r=30 w=%h", bus.round, bus.w_out, w_ref[30]);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if ({bus.valid, bus.round, bus.w_out, bus.sched_done} !== {1'b0, 6'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got v=%b r=%0d w=%h d=%b, want 0", bus.valid, bus.round, bus.w_out, bus.sched_done);
    end
    for (int t = 0; t < 10; t++) begin
      bus.advance = 1;
      tick();
      checks++;
      if (bus.valid !== 1'b0 || bus.round !== 6'd0) begin
        errors++;
        $display("FAIL idle_adv%0d: got v=%b r=%0d, want v=0 r=0", t, bus.valid, bus.round);
      end
    end
    bus.advance = 0;
  endtask

  task automatic test_random;
    for (int n = 0; n < 1000; n++) begin
      play_block(rand_block(), "random");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_back_to_back;
    int nvalid = 0;
    int dones = 0;
    load_block(rand_block());
    bus.advance = 1;
    for (int c = 0; c < 80; c++) begin
      if (bus.valid) begin
        checks++;
        if (nvalid > 63 || bus.w_out !== w_ref[nvalid & 63] || bus.round !== 6'(nvalid)) begin
          errors++;
          $display("FAIL held_adv word %0d: got r=%0d w=%h, want w=%h", nvalid, bus.round, bus.w_out, w_ref[nvalid & 63]);
        end
        nvalid++;
      end
      if (bus.sched_done) dones++;
      tick();
    end
    bus.advance = 0;
    checks++;
    if (nvalid != 64 || dones != 1 || bus.valid !== 1'b0 || bus.round !== 6'd0) begin
      errors++;
      $display("FAIL held_adv summary: got words=%0d dones=%0d v=%b r=%0d, want 64 1 0 0",
               nvalid, dones, bus.valid, bus.round);
    end
  endtask

  initial begin
    bus.load = 0;
    bus.advance = 0;
    bus.block_in = '0;
    test_reset();
    test_abc();
    test_load_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
